// File: rtl/i2c_master_ctrl.sv
// Single-master I2C controller: START, 7-bit address + R/W, one data byte, STOP.
// Open-drain lines (drive 0 or release); host side is start/busy/done.
// Optional feature macro: I2C_CLK_STRETCH_EN -- when defined, the quarter divider
// holds in Q2/Q3 while the synchronised SCL reads low (slave clock stretching).
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_addr,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_nack,
    inout  wire        io_scl,
    inout  wire        io_sda
);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_DATA,
        S_WR_ACK, S_RD_DATA, S_RD_NACK, S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       abyte_q, abyte_d;
    logic [7:0]       wbyte_q, wbyte_d;
    logic [7:0]       rx_q, rx_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             nack_q, nack_d;
    logic             scl_low_q, scl_low_d;
    logic             sda_low_q, sda_low_d;
    logic             sda_s1_q, sda_s2_q;
    logic             stall_c, qtick_c, sample_c, end_bit_c;

    assign io_scl  = scl_low_q ? 1'b0 : 1'bz;
    assign io_sda  = sda_low_q ? 1'b0 : 1'bz;
    assign o_rdata = rdata_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_nack  = nack_q;

`ifdef I2C_CLK_STRETCH_EN
    logic scl_s1_q, scl_s2_q;

    // Synchronise SCL so a slave holding it low can stretch the high quarters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= io_scl;
            scl_s2_q <= scl_s1_q;
        end
    end

    assign stall_c = (state_q != S_IDLE) && qtr_q[1] && !scl_s2_q;
`else
    assign stall_c = 1'b0;
`endif

    assign qtick_c   = !stall_c && (div_q == DIV_W'(CLK_DIV - 1));
    assign sample_c  = qtick_c && (qtr_q == 2'd2);
    assign end_bit_c = qtick_c && (qtr_q == 2'd3);

    // Two-flop synchroniser on the SDA input
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            sda_s1_q <= io_sda;
            sda_s2_q <= sda_s1_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            qtr_q     <= '0;
            bit_q     <= '0;
            abyte_q   <= '0;
            wbyte_q   <= '0;
            rx_q      <= '0;
            rdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
            scl_low_q <= 1'b0;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            abyte_q   <= abyte_d;
            wbyte_q   <= wbyte_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            nack_q    <= nack_d;
            scl_low_q <= scl_low_d;
            sda_low_q <= sda_low_d;
        end
    end

    // Next-state, quarter timebase and line drive decode
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        abyte_d   = abyte_q;
        wbyte_d   = wbyte_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        nack_d    = nack_q;
        sda_low_d = 1'b0;
        // Normal bit: SCL low in Q0/Q1, released in Q2/Q3
        scl_low_d = (state_q != S_IDLE) && !qtr_q[1];

        if ((state_q != S_IDLE) && !stall_c) begin
            if (qtick_c) begin
                div_d = '0;
                qtr_d = qtr_q + 2'd1;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                div_d = '0;
                qtr_d = '0;
                // A start coinciding with the done pulse is not taken
                if (i_start && !done_q) begin
                    abyte_d = {i_addr, i_rw};
                    wbyte_d = i_wdata;
                    nack_d  = 1'b0;
                    busy_d  = 1'b1;
                    bit_d   = 3'd7;
                    state_d = S_START;
                end
            end
            S_START: begin
                scl_low_d = (qtr_q == 2'd3);
                sda_low_d = qtr_q[1];
                if (end_bit_c) state_d = S_ADDR;
            end
            S_ADDR: begin
                sda_low_d = !abyte_q[bit_q];
                if (end_bit_c) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = S_ADDR_ACK;
                end
            end
            S_ADDR_ACK: begin
                if (sample_c && sda_s2_q) nack_d = 1'b1;
                if (end_bit_c) begin
                    if (nack_q)          state_d = S_STOP;
                    else if (abyte_q[0]) state_d = S_RD_DATA;
                    else                 state_d = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                sda_low_d = !wbyte_q[bit_q];
                if (end_bit_c) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = S_WR_ACK;
                end
            end
            S_WR_ACK: begin
                if (sample_c && sda_s2_q) nack_d = 1'b1;
                if (end_bit_c) state_d = S_STOP;
            end
            S_RD_DATA: begin
                if (sample_c) rx_d = {rx_q[6:0], sda_s2_q};
                if (end_bit_c) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q == 3'd0) state_d = S_RD_NACK;
                end
            end
            S_RD_NACK: begin
                if (sample_c) rdata_d = rx_q;
                if (end_bit_c) state_d = S_STOP;
            end
            S_STOP: begin
                scl_low_d = (qtr_q == 2'd0);
                sda_low_d = !qtr_q[1];
                if (end_bit_c) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Testbench for i2c_master_ctrl: behavioural I2C slave on pulled-up lines,
// randomized write/read transactions checked against a transaction-level model.
module tb_i2c_master_ctrl;
    localparam int unsigned N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    wire  [7:0] rdata;
    wire        busy, done, nack;
    wire        scl_w, sda_w;

    pullup pu_scl (scl_w);
    pullup pu_sda (sda_w);

    logic sl_sda_low = 1'b0;
    assign sda_w = sl_sda_low ? 1'b0 : 1'bz;

    i2c_master_ctrl #(.CLK_DIV(N)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_rw(rw),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_busy(busy),
        .o_done(done), .o_nack(nack), .io_scl(scl_w), .io_sda(sda_w)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0] exp_rdata = 8'h00;

    // Slave configuration
    logic [6:0] sl_addr = 7'h42;
    bit         sl_en = 1'b1;
    bit         sl_ack_data = 1'b1;
    logic [7:0] sl_rbyte = 8'h00;

    // Slave observation log
    logic [7:0] log_bytes[$];
    bit         log_nine[$];
    int         n_start = 0;
    int         n_stop = 0;

    int         bitn = 0;
    int         frame = 0;
    bit         rw_seen = 1'b0;
    bit         addr_ok = 1'b0;
    logic [7:0] shreg = '0;
    logic       p_scl = 1'b1, p_sda = 1'b1, c_scl, c_sda;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    // Behavioural slave: samples the bus every cycle and reacts to edges
    always @(negedge clk) begin
        c_scl = (scl_w !== 1'b0);
        c_sda = (sda_w !== 1'b0);
        if (rst) begin
            bitn = 0; frame = 0; sl_sda_low = 1'b0;
        end else if (p_scl && c_scl && p_sda && !c_sda) begin
            n_start++; bitn = 0; frame = 0; addr_ok = 1'b0; sl_sda_low = 1'b0;
        end else if (p_scl && c_scl && !p_sda && c_sda) begin
            n_stop++; sl_sda_low = 1'b0;
        end else if (!p_scl && c_scl) begin
            if (bitn < 8) shreg = {shreg[6:0], c_sda};
            else          log_nine.push_back(c_sda);
            bitn++;
            if (bitn == 8) begin
                log_bytes.push_back(shreg);
                if (frame == 0) begin
                    rw_seen = shreg[0];
                    addr_ok = sl_en && (shreg[7:1] == sl_addr);
                end
            end
        end else if (p_scl && !c_scl) begin
            sl_sda_low = 1'b0;
            if (bitn == 9) begin bitn = 0; frame++; end
            if (bitn == 8) begin
                if (frame == 0)                 sl_sda_low = addr_ok;
                else if (frame == 1 && !rw_seen) sl_sda_low = addr_ok && sl_ack_data;
            end else if (frame == 1 && rw_seen && addr_ok && bitn < 8) begin
                sl_sda_low = !sl_rbyte[7 - bitn];
            end
        end
        p_scl = c_scl;
        p_sda = c_sda;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one transaction; returns at the negedge where o_done is first seen
    task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] d,
                           input int inject_at, output int lat);
        log_bytes.delete(); log_nine.delete();
        n_start = 0; n_stop = 0;
        @(negedge clk);
        start = 1'b1; rw = r; addr = a; wdata = d;
        @(negedge clk);
        start = 1'b0; lat = 1;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_after_accept got %b want 1", busy);
        end
        while (done !== 1'b1 && lat < 4000) begin
            @(negedge clk);
            lat++;
            start = (lat == inject_at);
            if (lat == inject_at) begin addr = a ^ 7'h55; rw = ~r; wdata = ~d; end
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL done_timeout waited %0d cycles want done", lat);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (busy !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        if (done !== 1'b0)  begin errors++; $display("FAIL rst_done got %b want 0", done); end
        if (nack !== 1'b0)  begin errors++; $display("FAIL rst_nack got %b want 0", nack); end
        if (rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata got %h want 00", rdata); end
        if (scl_w !== 1'b1) begin errors++; $display("FAIL rst_scl got %b want 1", scl_w); end
        if (sda_w !== 1'b1) begin errors++; $display("FAIL rst_sda got %b want 1", sda_w); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Writes: fixed ACK case, fixed no-slave NACK case, then randomized
    task automatic test_write(input int iters);
        for (int it = 0; it < iters; it++) begin
            logic [6:0] a;
            logic [7:0] d;
            bit aok;
            int lat, exp_lat, dc0;
            if (it == 0) begin
                a = 7'h42; d = 8'hA5; sl_en = 1'b1; sl_addr = 7'h42; sl_ack_data = 1'b1;
            end else if (it == 1) begin
                a = 7'h11; d = 8'h77; sl_en = 1'b0;
            end else begin
                a = 7'($urandom); d = 8'($urandom); sl_en = 1'b1;
                sl_addr = ($urandom_range(0, 3) != 0) ? a : (a ^ 7'h01);
                sl_ack_data = 1'($urandom);
            end
            aok = sl_en && (a == sl_addr);
            exp_lat = (aok ? 20 : 11) * 4 * N;
            dc0 = done_cnt;
            run_txn(1'b0, a, d, 0, lat);
            checks += 7;
            if (lat < exp_lat - 2 || lat > exp_lat + 2) begin
                errors++; $display("FAIL wr_latency it%0d got %0d want %0d", it, lat, exp_lat); end
            if (log_bytes.size() != (aok ? 2 : 1)) begin
                errors++; $display("FAIL wr_nbytes it%0d got %0d want %0d", it, log_bytes.size(), aok ? 2 : 1); end
            if (log_bytes[0] !== {a, 1'b0}) begin
                errors++; $display("FAIL wr_addr_byte it%0d got %h want %h", it, log_bytes[0], {a, 1'b0}); end
            if (log_nine[0] != !aok) begin
                errors++; $display("FAIL wr_addr_ack it%0d got %0d want %0d", it, log_nine[0], !aok); end
            if (nack !== (!aok || !sl_ack_data)) begin
                errors++; $display("FAIL wr_nack it%0d got %b want %b", it, nack, (!aok || !sl_ack_data)); end
            if (rdata !== exp_rdata) begin
                errors++; $display("FAIL wr_rdata_kept it%0d got %h want %h", it, rdata, exp_rdata); end
            if (n_start != 1 || n_stop != 1) begin
                errors++; $display("FAIL wr_start_stop it%0d got %0d/%0d want 1/1", it, n_start, n_stop); end
            if (aok) begin
                checks += 2;
                if (log_bytes[1] !== d) begin
                    errors++; $display("FAIL wr_data_byte it%0d got %h want %h", it, log_bytes[1], d); end
                if (log_nine[1] != !sl_ack_data) begin
                    errors++; $display("FAIL wr_data_ack it%0d got %0d want %0d", it, log_nine[1], !sl_ack_data); end
            end
            repeat (3) @(negedge clk);
            checks += 2;
            if (done_cnt - dc0 != 1) begin
                errors++; $display("FAIL wr_done_pulses it%0d got %0d want 1", it, done_cnt - dc0); end
            if (busy !== 1'b0) begin
                errors++; $display("FAIL wr_busy_after it%0d got %b want 0", it, busy); end
        end
    endtask

    // Reads: fixed 0x42/0x3C case, then randomized with occasional wrong address
    task automatic test_read(input int iters);
        for (int it = 0; it < iters; it++) begin
            logic [6:0] a;
            bit aok;
            int lat, exp_lat, dc0;
            if (it == 0) begin
                a = 7'h42; sl_en = 1'b1; sl_addr = 7'h42; sl_rbyte = 8'h3C;
            end else begin
                a = 7'($urandom); sl_en = 1'b1; sl_rbyte = 8'($urandom);
                sl_addr = ($urandom_range(0, 3) != 0) ? a : (a ^ 7'h20);
            end
            aok = sl_en && (a == sl_addr);
            if (aok) exp_rdata = sl_rbyte;
            exp_lat = (aok ? 20 : 11) * 4 * N;
            dc0 = done_cnt;
            run_txn(1'b1, a, 8'h00, 0, lat);
            checks += 6;
            if (lat < exp_lat - 2 || lat > exp_lat + 2) begin
                errors++; $display("FAIL rd_latency it%0d got %0d want %0d", it, lat, exp_lat); end
            if (log_bytes[0] !== {a, 1'b1}) begin
                errors++; $display("FAIL rd_addr_byte it%0d got %h want %h", it, log_bytes[0], {a, 1'b1}); end
            if (log_nine[0] != !aok) begin
                errors++; $display("FAIL rd_addr_ack it%0d got %0d want %0d", it, log_nine[0], !aok); end
            if (nack !== !aok) begin
                errors++; $display("FAIL rd_nack it%0d got %b want %b", it, nack, !aok); end
            if (rdata !== exp_rdata) begin
                errors++; $display("FAIL rd_rdata it%0d got %h want %h", it, rdata, exp_rdata); end
            if (n_start != 1 || n_stop != 1) begin
                errors++; $display("FAIL rd_start_stop it%0d got %0d/%0d want 1/1", it, n_start, n_stop); end
            if (aok) begin
                checks += 2;
                if (log_bytes[1] !== sl_rbyte) begin
                    errors++; $display("FAIL rd_bus_byte it%0d got %h want %h", it, log_bytes[1], sl_rbyte); end
                if (log_nine[1] != 1'b1) begin
                    errors++; $display("FAIL rd_master_nack_bit it%0d got %0d want 1", it, log_nine[1]); end
            end
            repeat (3) @(negedge clk);
            checks++;
            if (done_cnt - dc0 != 1) begin
                errors++; $display("FAIL rd_done_pulses it%0d got %0d want 1", it, done_cnt - dc0); end
        end
    endtask

    // A start pulse mid-transaction must not disturb traffic or latched values
    task automatic test_ignore_start();
        int lat, dc0;
        logic [7:0] d;
        d = 8'($urandom);
        sl_en = 1'b1; sl_addr = 7'h42; sl_ack_data = 1'b1;
        dc0 = done_cnt;
        run_txn(1'b0, 7'h42, d, 100 + int'($urandom_range(0, 100)), lat);
        checks += 5;
        if (lat < 80 * N - 2 || lat > 80 * N + 2) begin
            errors++; $display("FAIL ign_latency got %0d want %0d", lat, 80 * N); end
        if (log_bytes.size() != 2) begin
            errors++; $display("FAIL ign_nbytes got %0d want 2", log_bytes.size()); end
        if (log_bytes[0] !== 8'h84) begin
            errors++; $display("FAIL ign_addr_byte got %h want 84", log_bytes[0]); end
        if (log_bytes[1] !== d) begin
            errors++; $display("FAIL ign_data_byte got %h want %h", log_bytes[1], d); end
        if (nack !== 1'b0) begin
            errors++; $display("FAIL ign_nack got %b want 0", nack); end
        repeat (3) @(negedge clk);
        checks += 2;
        if (done_cnt - dc0 != 1) begin
            errors++; $display("FAIL ign_done_pulses got %0d want 1", done_cnt - dc0); end
        if (n_start != 1) begin
            errors++; $display("FAIL ign_starts got %0d want 1", n_start); end
    endtask

    // Start during the done cycle is dropped; the next cycle's start is taken
    task automatic test_back_to_back();
        int lat;
        logic [7:0] d;
        sl_en = 1'b1; sl_addr = 7'h42; sl_ack_data = 1'b1;
        run_txn(1'b0, 7'h42, 8'h5A, 0, lat);
        start = 1'b1; addr = 7'h33; rw = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_start_on_done got busy %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width got %b want 0", done); end
        d = 8'($urandom);
        run_txn(1'b0, 7'h42, d, 0, lat);
        checks += 2;
        if (log_bytes[1] !== d) begin
            errors++; $display("FAIL b2b_data_byte got %h want %h", log_bytes[1], d); end
        if (lat < 80 * N - 2 || lat > 80 * N + 2) begin
            errors++; $display("FAIL b2b_latency got %0d want %0d", lat, 80 * N); end
        repeat (3) @(negedge clk);
    endtask

    // Reset during the 4th data bit aborts without STOP or done
    task automatic test_reset_mid();
        int lat, dc0;
        sl_en = 1'b1; sl_addr = 7'h42; sl_ack_data = 1'b1;
        dc0 = done_cnt;
        @(negedge clk);
        start = 1'b1; rw = 1'b0; addr = 7'h42; wdata = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        repeat (215) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 3;
        if (busy !== 1'b0)  begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
        if (scl_w !== 1'b1) begin errors++; $display("FAIL rmid_scl got %b want 1", scl_w); end
        if (sda_w !== 1'b1) begin errors++; $display("FAIL rmid_sda got %b want 1", sda_w); end
        rst = 1'b0;
        exp_rdata = 8'h00;
        repeat (400) @(negedge clk);
        checks += 2;
        if (done_cnt != dc0) begin errors++; $display("FAIL rmid_no_done got %0d pulses want 0", done_cnt - dc0); end
        if (rdata !== exp_rdata) begin errors++; $display("FAIL rmid_rdata got %h want %h", rdata, exp_rdata); end
        run_txn(1'b0, 7'h42, 8'h96, 0, lat);
        checks += 3;
        if (log_bytes[0] !== 8'h84 || log_bytes[1] !== 8'h96) begin
            errors++; $display("FAIL rmid_after_bytes got %h %h want 84 96", log_bytes[0], log_bytes[1]); end
        if (nack !== 1'b0) begin errors++; $display("FAIL rmid_after_nack got %b want 0", nack); end
        if (lat < 80 * N - 2 || lat > 80 * N + 2) begin
            errors++; $display("FAIL rmid_after_latency got %0d want %0d", lat, 80 * N); end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_write(8);
        test_read(6);
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
